// File: rtl/VX_gpu_pkg.sv
// rtl/VX_gpu_pkg.sv - shared memory-bus typedefs and sizing helpers
package VX_gpu_pkg;

    localparam int MEM_DATA_SIZE = 64;
    localparam int MEM_TAG_WIDTH = 8;
    localparam int MEM_RSP_DEPTH = 4;

    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int MEM_CREDIT_WIDTH = credit_width(MEM_RSP_DEPTH);

    typedef struct packed {
        logic [8*MEM_DATA_SIZE-1:0] data;
        logic [MEM_TAG_WIDTH-1:0]   tag;
    } mem_rsp_entry_t;

endpackage

// File: rtl/vx_mem_responder_buf.sv
// rtl/vx_mem_responder_buf.sv - in-order first-word-fall-through response buffer
module vx_mem_responder_buf
    import VX_gpu_pkg::*;
#(
    parameter int WIDTH = $bits(mem_rsp_entry_t),
    parameter int DEPTH = MEM_RSP_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = credit_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(i_pop && o_empty));

endmodule

// File: rtl/vx_mem_responder.sv
// rtl/vx_mem_responder.sv - fixed-latency SRAM memory responder; VX_MEM_RESPONDER_WACK_EN enables write acks
module vx_mem_responder
    import VX_gpu_pkg::*;
#(
    parameter int DATA_SIZE  = MEM_DATA_SIZE,
    parameter int ADDR_WIDTH = 10,
    parameter int TAG_WIDTH  = MEM_TAG_WIDTH,
    parameter int LATENCY    = 2,
    parameter int RSP_DEPTH  = MEM_RSP_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_rw,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [8*DATA_SIZE-1:0] req_data,
    input  logic [DATA_SIZE-1:0]   req_byteen,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic [8*DATA_SIZE-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    input  logic                   rsp_ready,
    output logic                   busy
);

    localparam int DW = 8 * DATA_SIZE;
    localparam int EW = DW + TAG_WIDTH;
    localparam int CW = credit_width(RSP_DEPTH);

    logic [DW-1:0] r_mem [2**ADDR_WIDTH];
    logic [CW-1:0] r_credits;

    logic          w_req_fire;
    logic          w_rsp_fire;
    logic          w_take;
    logic [DW-1:0] w_rd_data;
    logic [EW-1:0] w_in_entry;
    logic          w_push;
    logic [EW-1:0] w_push_entry;
    logic [EW-1:0] w_buf_dout;
    logic          w_buf_full;
    logic          w_buf_empty;

    assign req_ready  = ~reset & (r_credits != '0);
    assign w_req_fire = req_valid & req_ready;
    assign w_rsp_fire = rsp_valid & rsp_ready;

`ifdef VX_MEM_RESPONDER_WACK_EN
    assign w_take    = w_req_fire;
    assign w_rd_data = req_rw ? '0 : r_mem[req_addr];
`else
    assign w_take    = w_req_fire & ~req_rw;
    assign w_rd_data = r_mem[req_addr];
`endif
    assign w_in_entry = {w_rd_data, req_tag};

    always_ff @(posedge clk) begin
        if (w_req_fire && req_rw) begin
            for (int i = 0; i < DATA_SIZE; i++)
                if (req_byteen[i])
                    r_mem[req_addr][8*i +: 8] <= req_data[8*i +: 8];
        end
    end

    // Every response-producing request holds one credit until its response is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credits <= CW'(RSP_DEPTH);
        end else begin
            case ({w_take, w_rsp_fire})
                2'b10:   r_credits <= r_credits - CW'(1);
                2'b01:   r_credits <= r_credits + CW'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign w_push       = w_take;
            assign w_push_entry = w_in_entry;
        end else begin : g_pipe
            logic [LATENCY-2:0] r_pipe_valid;
            logic [EW-1:0]      r_pipe_entry [LATENCY-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pipe_valid <= '0;
                end else begin
                    r_pipe_valid[0] <= w_take;
                    for (int k = 1; k < LATENCY - 1; k++)
                        r_pipe_valid[k] <= r_pipe_valid[k-1];
                end
            end

            always_ff @(posedge clk) begin
                r_pipe_entry[0] <= w_in_entry;
                for (int k = 1; k < LATENCY - 1; k++)
                    r_pipe_entry[k] <= r_pipe_entry[k-1];
            end

            assign w_push       = r_pipe_valid[LATENCY-2];
            assign w_push_entry = r_pipe_entry[LATENCY-2];
        end
    endgenerate

    vx_mem_responder_buf #(
        .WIDTH (EW),
        .DEPTH (RSP_DEPTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_rsp_fire),
        .o_data  (w_buf_dout),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty)
    );

    assign rsp_valid = ~w_buf_empty;
    assign rsp_data  = rsp_valid ? w_buf_dout[EW-1:TAG_WIDTH] : '0;
    assign rsp_tag   = rsp_valid ? w_buf_dout[TAG_WIDTH-1:0]  : '0;
    assign busy      = (r_credits != CW'(RSP_DEPTH));

    a_no_push_full:    assert property (@(posedge clk) disable iff (reset) !(w_push && w_buf_full));
    a_credits_bounded: assert property (@(posedge clk) disable iff (reset) r_credits <= CW'(RSP_DEPTH));

endmodule

// File: tb/tb_vx_mem_responder.sv
// tb/tb_vx_mem_responder.sv - directed self-checking bench for vx_mem_responder
module tb_vx_mem_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_rw;
    logic [9:0]   req_addr;
    logic [511:0] req_data;
    logic [63:0]  req_byteen;
    logic [7:0]   req_tag;
    logic         req_ready;
    logic         rsp_valid;
    logic [511:0] rsp_data;
    logic [7:0]   rsp_tag;
    logic         rsp_ready;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vx_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_byteen (req_byteen),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [511:0] d, input logic [63:0] be, input logic [7:0] t);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = a; req_data = d; req_byteen = be; req_tag = t;
        @(negedge clk);
        req_valid = 1'b0; req_rw = 1'b0;
`ifdef VX_MEM_RESPONDER_WACK_EN
        repeat (3) @(negedge clk);
`endif
    endtask

    task automatic rd_lat(input logic [9:0] a, input logic [7:0] t, input logic [511:0] exp);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = a; req_tag = t;
        check("rd_ready", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        check("rd_lat_t1_idle", rsp_valid, 1'b0);
        @(negedge clk);
        check("rd_lat_t2_valid", rsp_valid, 1'b1);
        check("rd_data", rsp_data, exp);
        check("rd_tag", rsp_tag, t);
        @(negedge clk);
    endtask

    logic [7:0]   got_tags[$];
    logic [511:0] got_data[$];
    logic [511:0] pattern;
    logic [7:0]   b;

    initial begin
        int next, cyc, first_cyc, last_cyc, cnt;
        logic fire_req;

        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0;
        req_data = '0; req_byteen = '0; req_tag = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_rsp_tag", rsp_tag, '0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 1'b1);
        @(negedge clk);

        // Full write then read with latency check
        wr(10'd5, {64{8'hAA}}, {64{1'b1}}, 8'h00);
        rd_lat(10'd5, 8'h11, {64{8'hAA}});

        // Partial byte-enable write
        wr(10'd5, 512'h55, 64'h1, 8'h00);
        rd_lat(10'd5, 8'h12, {{63{8'hAA}}, 8'h55});

        // Backpressure: four credits, then stall
        rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            req_valid = 1'b1; req_rw = 1'b0; req_addr = 10'(i); req_tag = 8'(i);
            check("bp_accept", req_ready, 1'b1);
            @(negedge clk);
        end
        req_addr = 10'd5; req_tag = 8'd5;
        check("bp_stalled", req_ready, 1'b0);
        check("bp_busy", busy, 1'b1);
        repeat (3) @(negedge clk);
        check("bp_hold_valid", rsp_valid, 1'b1);
        check("bp_hold_tag", rsp_tag, 8'd1);
        check("bp_still_stalled", req_ready, 1'b0);
        rsp_ready = 1'b1;
        got_tags.delete();
        next = 5;
        for (cyc = 0; cyc < 40 && got_tags.size() < 6; cyc++) begin
            fire_req = req_valid & req_ready;
            if (rsp_valid) got_tags.push_back(rsp_tag);
            @(negedge clk);
            if (fire_req) begin
                next++;
                if (next > 6) req_valid = 1'b0;
                else begin req_addr = 10'(next); req_tag = 8'(next); end
            end
        end
        req_valid = 1'b0;
        check("bp_rsp_count", got_tags.size(), 6);
        for (int k = 0; k < got_tags.size(); k++)
            check("bp_order", got_tags[k], 8'(k + 1));
        repeat (2) @(negedge clk);
        check("bp_idle_busy", busy, 1'b0);

        // Streaming reads over pre-written addresses
        for (int i = 0; i < 16; i++) begin
            b = 8'(i * 3 + 1);
            pattern = {64{b}};
            wr(10'(i), pattern, {64{1'b1}}, 8'h00);
        end
        got_tags.delete(); got_data.delete();
        next = 0; first_cyc = -1; last_cyc = -1;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 10'd0; req_tag = 8'h20;
        for (cyc = 0; cyc < 60 && got_tags.size() < 16; cyc++) begin
            if (req_valid) check("stream_ready", req_ready, 1'b1);
            fire_req = req_valid & req_ready;
            if (rsp_valid) begin
                got_tags.push_back(rsp_tag);
                got_data.push_back(rsp_data);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            @(negedge clk);
            if (fire_req) begin
                next++;
                if (next >= 16) req_valid = 1'b0;
                else begin req_addr = 10'(next); req_tag = 8'(8'h20 + next); end
            end
        end
        req_valid = 1'b0;
        check("stream_count", got_tags.size(), 16);
        check("stream_contiguous", last_cyc - first_cyc, 15);
        for (int k = 0; k < got_tags.size(); k++) begin
            b = 8'(k * 3 + 1);
            pattern = {64{b}};
            check("stream_tag", got_tags[k], 8'(8'h20 + k));
            check("stream_data", got_data[k], pattern);
        end
        @(negedge clk);

        // Reset with reads in flight; memory must survive
        wr(10'd9, {64{8'h33}}, {64{1'b1}}, 8'h00);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_rw = 1'b0; req_addr = 10'd9; req_tag = 8'(8'h31 + i);
            @(negedge clk);
        end
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_ready", req_ready, 1'b0);
        check("midrst_valid", rsp_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        reset = 1'b0; rsp_ready = 1'b1;
        #1;
        check("midrst_ready_after", req_ready, 1'b1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) cnt++;
            @(negedge clk);
        end
        check("midrst_no_rsp", cnt, 0);
        rd_lat(10'd9, 8'h40, {64{8'h33}});

        // Write response behaviour
`ifdef VX_MEM_RESPONDER_WACK_EN
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 10'd20; req_data = {64{8'h77}};
        req_byteen = {64{1'b1}}; req_tag = 8'h07;
        @(negedge clk);
        req_valid = 1'b0; req_rw = 1'b0;
        check("wack_t1_idle", rsp_valid, 1'b0);
        @(negedge clk);
        check("wack_valid", rsp_valid, 1'b1);
        check("wack_tag", rsp_tag, 8'h07);
        check("wack_data", rsp_data, '0);
        @(negedge clk);
`else
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 10'd20; req_data = {64{8'h77}};
        req_byteen = {64{1'b1}}; req_tag = 8'h07;
        @(negedge clk);
        req_valid = 1'b0; req_rw = 1'b0;
        check("wr_no_credit", busy, 1'b0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) cnt++;
            @(negedge clk);
        end
        check("wr_no_rsp", cnt, 0);
`endif
        rd_lat(10'd20, 8'h41, {64{8'h77}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
